// File: rtl/adc_i2s_rx.sv
// I2S receiver for the ADC serial stream: oversamples BCK/LRCK/SDATA in the MCK domain,
// deserialises left/right words and only publishes stereo pairs once framing is locked.
module adc_i2s_rx #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned SLOT_W      = 32,
  parameter int unsigned LOCK_HALVES = 4,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic              MCK_in,
  input  logic              RST_in,
  input  logic              BCK_in,
  input  logic              LRCK_in,
  input  logic              SDATA_in,
  output logic [DATA_W-1:0] L_DATA_out,
  output logic [DATA_W-1:0] R_DATA_out,
  output logic              VALID_out,
  output logic              LOCK_out,
  output logic              ERR_out
);

  localparam int unsigned N_W   = $clog2(2 * SLOT_W);
  localparam int unsigned N_MAX = 2 * SLOT_W - 1;
  localparam int unsigned T_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned C_W   = $clog2(LOCK_HALVES + 1);

  typedef enum logic [1:0] {UNLOCKED, SYNC, LOCKED} state_t;

  state_t            state, state_nx;
  logic              s1_bck, s2_bck, s1_lrck, s1_sdata;
  logic              rise, primed, prev_lrck, change, good, timeout_hit, capture;
  logic [N_W-1:0]    n, n_nx;
  logic [T_W-1:0]    to_cnt;
  logic [C_W-1:0]    good_cnt, good_cnt_nx;
  logic [DATA_W-1:0] shreg, shreg_nx, l_hold;
  logic              commit, commit_lrck, err_nx;

  // prev_lrck is only meaningful after the first rise following reset (primed),
  // so a reset in mid-half never looks like an LRCK edge.
  always_comb begin
    rise        = s1_bck & ~s2_bck;
    change      = rise & primed & (s1_lrck != prev_lrck);
    good        = (n == N_W'(SLOT_W - 1));
    timeout_hit = ~rise & (to_cnt == T_W'(TIMEOUT - 1));
    if (change || !primed)
      n_nx = '0;
    else if (n == N_W'(N_MAX))
      n_nx = n;
    else
      n_nx = n + 1'b1;
    capture  = rise && (n_nx != '0) && (n_nx <= N_W'(DATA_W));
    shreg_nx = DATA_W'({shreg, s1_sdata});
  end

  always_comb begin
    state_nx    = state;
    good_cnt_nx = good_cnt;
    err_nx      = 1'b0;
    if (change) begin
      case (state)
        UNLOCKED: begin
          state_nx    = SYNC;
          good_cnt_nx = '0;
        end
        SYNC: begin
          if (good) begin
            good_cnt_nx = good_cnt + 1'b1;
            if (good_cnt == C_W'(LOCK_HALVES - 1))
              state_nx = LOCKED;
          end else begin
            state_nx    = UNLOCKED;
            good_cnt_nx = '0;
            err_nx      = 1'b1;
          end
        end
        default: begin
          if (!good) begin
            state_nx    = UNLOCKED;
            good_cnt_nx = '0;
            err_nx      = 1'b1;
          end
        end
      endcase
    end
    if (timeout_hit && state != UNLOCKED) begin
      state_nx    = UNLOCKED;
      good_cnt_nx = '0;
      err_nx      = 1'b1;
    end
  end

  always_comb LOCK_out = (state == LOCKED);

  always_ff @(posedge MCK_in) begin
    if (RST_in) begin
      s1_bck      <= 1'b0;
      s2_bck      <= 1'b0;
      s1_lrck     <= 1'b0;
      s1_sdata    <= 1'b0;
      state       <= UNLOCKED;
      good_cnt    <= '0;
      n           <= '0;
      to_cnt      <= '0;
      primed      <= 1'b0;
      prev_lrck   <= 1'b0;
      shreg       <= '0;
      l_hold      <= '0;
      commit      <= 1'b0;
      commit_lrck <= 1'b0;
      L_DATA_out  <= '0;
      R_DATA_out  <= '0;
      VALID_out   <= 1'b0;
      ERR_out     <= 1'b0;
    end else begin
      s1_bck      <= BCK_in;
      s2_bck      <= s1_bck;
      s1_lrck     <= LRCK_in;
      s1_sdata    <= SDATA_in;
      state       <= state_nx;
      good_cnt    <= good_cnt_nx;
      ERR_out     <= err_nx;
      VALID_out   <= 1'b0;
      commit      <= change;
      commit_lrck <= s1_lrck;
      if (rise) begin
        to_cnt    <= '0;
        n         <= n_nx;
        primed    <= 1'b1;
        prev_lrck <= s1_lrck;
        if (capture)
          shreg <= shreg_nx;
      end else if (to_cnt != T_W'(TIMEOUT)) begin
        to_cnt <= to_cnt + 1'b1;
      end
      // Rises are never back to back, so shreg still holds the closed word here.
      if (commit) begin
        if (commit_lrck) begin
          l_hold <= shreg;
        end else if (state == LOCKED) begin
          L_DATA_out <= l_hold;
          R_DATA_out <= shreg;
          VALID_out  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_i2s_rx.sv
// Scoreboard bench for adc_i2s_rx: drives I2S frames from MCK-synchronous tasks and
// checks every VALID_out pair against a half-frame level model of the lock behaviour.
module tb_adc_i2s_rx;

  logic        mck = 1'b0;
  logic        rst = 1'b1, bck = 1'b0, lrck = 1'b0, sdata = 1'b0;
  logic [23:0] l_data, r_data;
  logic        valid, lock, err;

  int errors = 0, checks = 0, cyc = 0, last_valid = -1, spacing = 0;
  int err_seen = 0, exp_err = 0;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;
  pair_t q[$];
  pair_t mon_e;

  int          m_state = 0, m_cnt = 0, m_prev_len = 0;
  logic        m_primed = 1'b0, m_prev_lrck = 1'b0;
  logic [23:0] m_lw = '0, m_rw = '0;

  adc_i2s_rx #(.DATA_W(24), .SLOT_W(32), .LOCK_HALVES(4), .TIMEOUT(16)) dut (
    .MCK_in    (mck),
    .RST_in    (rst),
    .BCK_in    (bck),
    .LRCK_in   (lrck),
    .SDATA_in  (sdata),
    .L_DATA_out(l_data),
    .R_DATA_out(r_data),
    .VALID_out (valid),
    .LOCK_out  (lock),
    .ERR_out   (err)
  );

  always #5 mck = ~mck;

  always @(negedge mck) begin
    cyc++;
    if (err === 1'b1) err_seen++;
    if (valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got L=%h R=%h, required no VALID_out", l_data, r_data);
      end else begin
        mon_e = q.pop_front();
        if (l_data !== mon_e.l || r_data !== mon_e.r) begin
          errors++;
          $display("FAIL valid_pair: got L=%h R=%h, expected L=%h R=%h", l_data, r_data, mon_e.l, mon_e.r);
        end
      end
      if (spacing != 0 && last_valid >= 0) begin
        checks++;
        if (cyc - last_valid != spacing) begin
          errors++;
          $display("FAIL valid_spacing: got %0d, expected %0d", cyc - last_valid, spacing);
        end
      end
      last_valid = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic model_start(input logic lr, input logic [23:0] w);
    logic ok;
    if (!m_primed) begin
      m_primed    = 1'b1;
      m_prev_lrck = lr;
      m_prev_len  = 0;
    end else if (lr != m_prev_lrck) begin
      ok = (m_prev_len == 32);
      case (m_state)
        0: begin m_state = 1; m_cnt = 0; end
        1: begin
          if (ok) begin
            m_cnt++;
            if (m_cnt == 4) m_state = 2;
          end else begin
            m_state = 0; m_cnt = 0; exp_err++;
          end
        end
        default: if (!ok) begin m_state = 0; m_cnt = 0; exp_err++; end
      endcase
      if (m_state == 2 && lr == 1'b0) q.push_back(pair_t'({m_lw, m_rw}));
      m_prev_lrck = lr;
      m_prev_len  = 0;
    end
    if (lr) m_rw = w;
    else    m_lw = w;
  endtask

  task automatic send_bit(input logic lr, input logic d, input int p);
    bck = 1'b0; lrck = lr; sdata = d;
    repeat (p / 2) @(posedge mck);
    #1 bck = 1'b1;
    repeat (p / 2) @(posedge mck);
    #1;
  endtask

  task automatic send_bits(input logic lr, input logic [23:0] w, input int p,
                           input int k0, input int k1, input logic pad);
    logic d;
    if (k0 == 0) model_start(lr, w);
    for (int k = k0; k < k1; k++) begin
      if (k >= 1 && k <= 24) d = w[24-k];
      else if (k >= 25)      d = pad;
      else                   d = 1'b0;
      send_bit(lr, d, p);
    end
    m_prev_len += k1 - k0;
  endtask

  task automatic send_frame(input logic [23:0] lw, input logic [23:0] rw, input int p, input logic pad);
    send_bits(1'b0, lw, p, 0, 32, pad);
    send_bits(1'b1, rw, p, 0, 32, pad);
  endtask

  task automatic do_reset();
    rst = 1'b1; bck = 1'b0; lrck = 1'b0; sdata = 1'b0;
    repeat (3) @(posedge mck);
    #1 rst = 1'b0;
    m_state = 0; m_cnt = 0; m_primed = 1'b0; m_prev_len = 0;
    spacing = 0; last_valid = -1;
    q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge mck);
    checks++;
    if ({l_data, r_data} !== 48'h0) begin
      errors++; $display("FAIL reset_data: got L=%h R=%h, expected 0", l_data, r_data);
    end
    checks++;
    if ({valid, lock, err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b, expected 000", {valid, lock, err});
    end
    @(posedge mck); #1;
  endtask

  task automatic test_48k();
    do_reset();
    repeat (2) send_frame(24'hA5A5A5, 24'h5A5A5A, 8, 1'b0);
    checks++;
    if (lock !== 1'b0) begin errors++; $display("FAIL lock_early: got %b, expected 0", lock); end
    send_frame(24'hA5A5A5, 24'h5A5A5A, 8, 1'b0);
    checks++;
    if (lock !== 1'b1) begin errors++; $display("FAIL lock_after_4: got %b, expected 1", lock); end
    spacing = 512; last_valid = -1;
    repeat (4) send_frame(24'hA5A5A5, 24'h5A5A5A, 8, 1'b0);
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL 48k_pending: got %0d, expected 0", q.size()); end
    checks++;
    if (l_data !== 24'hA5A5A5 || r_data !== 24'h5A5A5A) begin
      errors++; $display("FAIL 48k_data: got L=%h R=%h, expected A5A5A5/5A5A5A", l_data, r_data);
    end
    checks++;
    if (err_seen != 0) begin errors++; $display("FAIL 48k_err: got %0d, expected 0", err_seen); end
  endtask

  task automatic test_96k_ramp();
    logic [23:0] li;
    do_reset();
    spacing = 256;
    for (int i = 0; i < 10; i++) begin
      li = 24'(i);
      send_frame(li, ~li, 4, 1'b1);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL 96k_skipped: got %0d, expected 0", q.size()); end
    checks++;
    if (l_data !== 24'd8 || r_data !== ~24'd8) begin
      errors++; $display("FAIL 96k_last: got L=%h R=%h, expected 000008/fffff7", l_data, r_data);
    end
    checks++;
    if (lock !== 1'b1 || err_seen != exp_err) begin
      errors++; $display("FAIL 96k_state: got lock=%b err=%0d, expected 1/%0d", lock, err_seen, exp_err);
    end
  endtask

  task automatic test_fs_switch();
    int e0;
    do_reset();
    for (int f = 0; f < 4; f++) send_frame(24'hC00000 | 24'(f), 24'h300000 | 24'(f), 8, 1'b0);
    e0 = err_seen;
    send_bits(1'b0, 24'hC0FFEE, 8, 0, 16, 1'b0);
    send_bits(1'b0, 24'hC0FFEE, 4, 16, 32, 1'b0);
    send_bits(1'b1, 24'h0BEEF0, 4, 0, 32, 1'b0);
    for (int f = 0; f < 2; f++) send_frame(24'h123400 | 24'(f), 24'h567800 | 24'(f), 4, 1'b0);
    checks++;
    if (err_seen != e0) begin errors++; $display("FAIL switch_err: got %0d, expected %0d", err_seen, e0); end
    checks++;
    if (lock !== 1'b1) begin errors++; $display("FAIL switch_lock: got %b, expected 1", lock); end
    send_bits(1'b0, 24'h111111, 4, 0, 32, 1'b0);
    send_bits(1'b1, 24'h222222, 4, 0, 31, 1'b0);
    send_bits(1'b0, 24'h333333, 4, 0, 32, 1'b0);
    checks++;
    if (err_seen - e0 != 1) begin errors++; $display("FAIL short_err: got %0d, expected 1", err_seen - e0); end
    checks++;
    if (lock !== 1'b0) begin errors++; $display("FAIL short_unlock: got %b, expected 0", lock); end
    send_bits(1'b1, 24'h444444, 4, 0, 32, 1'b0);
    for (int f = 0; f < 2; f++) send_frame(24'h0A0A00 | 24'(f), 24'h0B0B00 | 24'(f), 4, 1'b0);
    checks++;
    if (lock !== 1'b1) begin errors++; $display("FAIL short_relock: got %b, expected 1", lock); end
    send_frame(24'h777777, 24'h888888, 4, 1'b0);
    checks++;
    if (q.size() != 0 || err_seen != exp_err) begin
      errors++; $display("FAIL switch_final: got pend=%0d err=%0d, expected 0/%0d", q.size(), err_seen, exp_err);
    end
  endtask

  task automatic test_timeout();
    int e0;
    do_reset();
    for (int f = 0; f < 4; f++) send_frame(24'hD00000 | 24'(f), 24'hE00000 | 24'(f), 8, 1'b0);
    send_bits(1'b0, 24'hABCDEF, 8, 0, 10, 1'b0);
    e0 = err_seen;
    bck = 1'b0;
    repeat (20) @(posedge mck);
    #1;
    exp_err++; m_state = 0; m_cnt = 0;
    checks++;
    if (err_seen - e0 != 1) begin errors++; $display("FAIL timeout_err: got %0d, expected 1", err_seen - e0); end
    checks++;
    if (lock !== 1'b0) begin errors++; $display("FAIL timeout_unlock: got %b, expected 0", lock); end
    send_bits(1'b0, 24'hABCDEF, 8, 10, 32, 1'b0);
    send_bits(1'b1, 24'hFEDCBA, 8, 0, 32, 1'b0);
    for (int f = 0; f < 2; f++) send_frame(24'h606000 | 24'(f), 24'h909000 | 24'(f), 8, 1'b0);
    checks++;
    if (lock !== 1'b1) begin errors++; $display("FAIL timeout_relock: got %b, expected 1", lock); end
    send_frame(24'h135790, 24'h246800, 8, 1'b0);
    checks++;
    if (q.size() != 0 || err_seen != exp_err) begin
      errors++; $display("FAIL timeout_final: got pend=%0d err=%0d, expected 0/%0d", q.size(), err_seen, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int f = 0; f < 4; f++) send_frame(24'h0F0F00 | 24'(f), 24'hF0F000 | 24'(f), 8, 1'b0);
    send_bits(1'b0, 24'h55AA55, 8, 0, 32, 1'b0);
    send_bits(1'b1, 24'hAA55AA, 8, 0, 12, 1'b0);
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL pre_reset_pending: got %0d, expected 0", q.size()); end
    rst = 1'b1;
    @(posedge mck);
    #1 rst = 1'b0;
    m_state = 0; m_cnt = 0; m_primed = 1'b1; m_prev_lrck = 1'b1;
    @(negedge mck);
    checks++;
    if ({l_data, r_data} !== 48'h0) begin
      errors++; $display("FAIL midreset_data: got L=%h R=%h, expected 0", l_data, r_data);
    end
    checks++;
    if ({valid, lock, err} !== 3'b000) begin
      errors++; $display("FAIL midreset_flags: got %b, expected 000", {valid, lock, err});
    end
    @(posedge mck); #1;
    send_bits(1'b1, 24'hAA55AA, 8, 12, 32, 1'b0);
    for (int f = 0; f < 3; f++) send_frame(24'h818100 | 24'(f), 24'h424200 | 24'(f), 8, 1'b0);
    checks++;
    if (lock !== 1'b1) begin errors++; $display("FAIL midreset_relock: got %b, expected 1", lock); end
    checks++;
    if (q.size() != 0 || err_seen != exp_err) begin
      errors++; $display("FAIL midreset_final: got pend=%0d err=%0d, expected 0/%0d", q.size(), err_seen, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_48k();
    test_96k_ramp();
    test_fs_switch();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
